// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall encodings, exception codes and FSM states
// for the pipeline controller, plus the stall-request priority encoder.
package pipe_ctrl_pkg;

    // Stall vector encodings: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
    localparam logic [5:0] STALL_NONE  = 6'b000000;
    localparam logic [5:0] STALL_IF    = 6'b000011;
    localparam logic [5:0] STALL_ID    = 6'b000111;
    localparam logic [5:0] STALL_EX    = 6'b001111;
    localparam logic [5:0] STALL_MEM   = 6'b011111;
    localparam logic [5:0] STALL_DRAIN = 6'b000011;

    // MEM-stage exception codes
    localparam logic [31:0] EXC_NONE = 32'h0000_0000;
    localparam logic [31:0] EXC_ERET = 32'h0000_000E;

    // Controller FSM states
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } pc_state_e;

    // The deepest requesting stage wins; it freezes itself and everything upstream.
    function automatic logic [5:0] stall_from_req(input logic req_if, input logic req_id,
                                                  input logic req_ex, input logic req_mem);
        logic [5:0] s;
        s = STALL_NONE;
        if (req_mem)     s = STALL_MEM;
        else if (req_ex) s = STALL_EX;
        else if (req_id) s = STALL_ID;
        else if (req_if) s = STALL_IF;
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall-request / exception inputs and stall / flush / redirect
// outputs between the pipeline stages and the pipeline controller.
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;

    // Pipeline side: raises requests and exceptions, consumes stall/flush
    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc
    );

    // Controller side
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excepttype_i, cp0_epc_i,
        output stall, flush, new_pc
    );
endinterface

// File: rtl/pipe_ctrl_watchdog.sv
// pipe_ctrl_watchdog: counts consecutive request-driven stall cycles and
// raises a sticky flag once the count reaches STALL_TIMEOUT.
module pipe_ctrl_watchdog #(
    parameter int unsigned STALL_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic cnt_en,     // this cycle is a request-driven stall in RUN
    output logic timeout
);
    logic [15:0] wcnt_reg, wcnt_next;
    logic        flag_reg, flag_next;

    // Count up while stalled (saturating), clear on any other cycle; flag is sticky
    always_comb begin
        wcnt_next = 16'd0;
        flag_next = flag_reg;
        if (cnt_en) begin
            wcnt_next = (wcnt_reg == 16'hFFFF) ? wcnt_reg : wcnt_reg + 16'd1;
            if (({16'd0, wcnt_reg} + 32'd1) >= 32'(STALL_TIMEOUT))
                flag_next = 1'b1;
        end
    end

    // Counter and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_reg <= 16'd0;
            flag_reg <= 1'b0;
        end else begin
            wcnt_reg <= wcnt_next;
            flag_reg <= flag_next;
        end
    end

    assign timeout = flag_reg;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stall requests, turns MEM exceptions into
// flush/new_pc, holds fetch for DRAIN_CYCLES after each flush.
// Optional watchdog is built when PIPE_CTRL_WATCHDOG_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_BASE      = 32'hBFC0_0380,
    parameter int unsigned DRAIN_CYCLES  = 2,
    parameter int unsigned STALL_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus,
    output logic       busy_o,
    output logic       stall_timeout_o
);
    // Out-of-range parameters are caught at elaboration
    if (DRAIN_CYCLES > 15) begin : g_bad_drain
        $error("pipe_ctrl: DRAIN_CYCLES must be 0..15");
    end
    if (STALL_TIMEOUT < 1 || STALL_TIMEOUT > 65535) begin : g_bad_timeout
        $error("pipe_ctrl: STALL_TIMEOUT must be 1..65535");
    end

    pc_state_e   state_reg, state_next;
    logic [3:0]  dcnt_reg, dcnt_next;
    logic [5:0]  stall_next;
    logic        flush_next;
    logic [31:0] new_pc_next;
    logic        busy_next;
    logic        exc_pending;

    assign exc_pending = (bus.excepttype_i != EXC_NONE);

    // Next-state and outputs; reset forces the outputs to idle immediately
    always_comb begin
        state_next  = state_reg;
        dcnt_next   = dcnt_reg;
        stall_next  = STALL_NONE;
        flush_next  = 1'b0;
        new_pc_next = 32'd0;
        busy_next   = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_RUN: begin
                    if (exc_pending) begin
                        // Exception beats any stall request: the stages get flushed anyway
                        flush_next  = 1'b1;
                        new_pc_next = (bus.excepttype_i == EXC_ERET) ? bus.cp0_epc_i : EXC_BASE;
                        if (DRAIN_CYCLES != 0) begin
                            state_next = ST_DRAIN;
                            dcnt_next  = 4'(DRAIN_CYCLES - 1);
                        end
                    end else begin
                        stall_next = stall_from_req(bus.stallreq_if, bus.stallreq_id,
                                                    bus.stallreq_ex, bus.stallreq_mem);
                    end
                end
                ST_DRAIN: begin
                    // Fetch held; exceptions and requests ignored until drained
                    stall_next = STALL_DRAIN;
                    busy_next  = 1'b1;
                    if (dcnt_reg == 4'd0) state_next = ST_RUN;
                    else                  dcnt_next  = dcnt_reg - 4'd1;
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    // FSM state and drain counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RUN;
            dcnt_reg  <= 4'd0;
        end else begin
            state_reg <= state_next;
            dcnt_reg  <= dcnt_next;
        end
    end

    assign bus.stall  = stall_next;
    assign bus.flush  = flush_next;
    assign bus.new_pc = new_pc_next;
    assign busy_o     = busy_next;

`ifdef PIPE_CTRL_WATCHDOG_EN
    logic wd_cnt_en;

    // Only request-driven stalls in RUN count; drain, flush and idle cycles clear
    assign wd_cnt_en = (state_reg == ST_RUN) && !exc_pending && (stall_next != STALL_NONE);

    pipe_ctrl_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .cnt_en  (wd_cnt_en),
        .timeout (stall_timeout_o)
    );
`else
    assign stall_timeout_o = 1'b0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the 5-stage MIPS core. It merges per-stage stall requests into the 6-bit `stall` vector consumed by `pc_reg` and the pipeline registers. It turns the MEM-stage exception type into the `flush`/`new_pc` pair. After every flush it sequences a short fetch-drain window, and it optionally watches for pipeline deadlock.

## Interface
Parameters:
- `EXC_BASE`, 32'hBFC0_0380: `new_pc` for every exception other than ERET.
- `DRAIN_CYCLES`, 2: cycles (0..15) of fetch hold after a flush.
- `STALL_TIMEOUT`, 255: consecutive request-stall cycles before the watchdog trips (1..65535).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `stallreq_if` in 1: stall request from IF.
- `stallreq_id` in 1: stall request from ID.
- `stallreq_ex` in 1: stall request from EX.
- `stallreq_mem` in 1: stall request from MEM.
- `excepttype_i` in 32: MEM-stage exception code; 0 means none, 32'h0000_000E means ERET.
- `cp0_epc_i` in 32: current CP0 EPC.
- `stall` out 6: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- `flush` out 1: clears all pipeline registers; `pc_reg` loads `new_pc`.
- `new_pc` out 32: redirect target, valid when `flush`=1.
- `busy_o` out 1: high while in DRAIN.
- `stall_timeout_o` out 1: sticky watchdog flag.

## Operation
- FSM states: RUN and DRAIN. Reset enters RUN. Drain counter `dcnt` is 4 bits.
- RUN, `excepttype_i`≠0:
  - `flush`=1 and `stall`=0, regardless of stall requests.
  - `new_pc` = `cp0_epc_i` if the code is ERET, else `EXC_BASE`.
  - If `DRAIN_CYCLES`>0, go to DRAIN with `dcnt`=`DRAIN_CYCLES`-1; otherwise stay in RUN.
- RUN, no exception: `flush`=0, `new_pc`=0. `stall` comes from the highest requesting stage:
  - MEM → 6'b011111
  - EX → 6'b001111
  - ID → 6'b000111
  - IF → 6'b000011
  - none → 0
- DRAIN:
  - `stall`=6'b000011 and `busy_o`=1.
  - `excepttype_i` and all stall requests are ignored: `flush`=0.
  - `dcnt` decrements each cycle; when `dcnt`=0, the next state is RUN.
- `stall`, `flush` and `new_pc` are combinational from state and inputs. State, `dcnt` and the watchdog are registered.
- Watchdog (macro only):
  - 16-bit counter `wcnt` increments in RUN each cycle `stall`≠0 from requests and clears on any cycle with `stall`=0, in DRAIN, or on `flush`.
  - When `wcnt` reaches `STALL_TIMEOUT`, set `stall_timeout_o`. It holds until reset. `wcnt` saturates.
- Reset mid-drain or mid-stall: state goes to RUN, `dcnt`=0, `wcnt`=0, flag cleared.

## Timing
- Reset values: `stall`=0, `flush`=0, `new_pc`=0, `busy_o`=0, `stall_timeout_o`=0, state RUN.
- Exception seen in cycle T:
  - `flush`/`new_pc` are valid in T; `pc_reg` loads `new_pc` at the T+1 edge.
  - `stall`=6'b000011 during T+1..T+`DRAIN_CYCLES`; RUN resumes at T+`DRAIN_CYCLES`+1.
- Stall response to a request has zero-cycle latency (same cycle).
- Watchdog sets the flag at the edge ending the `STALL_TIMEOUT`-th consecutive stall cycle.
- Simultaneous exception and stall request: the exception wins and the request is dropped that cycle. The requesting stage is flushed anyway.

## Configuration
- `PIPE_CTRL_WATCHDOG_EN` defined: watchdog counter and sticky flag are built.
- Not defined: no counter logic; `stall_timeout_o` is tied to 0 and `STALL_TIMEOUT` is unused.

## Structure
- Shared defines hold:
  - stall encodings (`STALL_NONE`, `STALL_IF`, `STALL_ID`, `STALL_EX`, `STALL_MEM`, `STALL_DRAIN`)
  - exception code `EXC_ERET`=32'h0000_000E
  - FSM state constants
- One sub-module, `pipe_ctrl_watchdog`, holds `wcnt` and the sticky flag. It is instantiated only under the macro.

## Test plan
- Reset, then `stallreq_ex`=1 for 3 cycles → `stall`=6'b001111 for those 3 cycles, `flush`=0; the request drops → `stall`=0.
- `stallreq_id`=1 and `stallreq_mem`=1 together → `stall`=6'b011111.
- `excepttype_i`=32'h1 in cycle T with `stallreq_ex`=1:
  - T: `flush`=1, `new_pc`=32'hBFC0_0380, `stall`=0.
  - T+1, T+2: `stall`=6'b000011, `busy_o`=1.
  - T+3: RUN.
- ERET with `cp0_epc_i`=32'h0000_1234 → `new_pc`=32'h0000_1234. A second exception and `stallreq_mem` driven during DRAIN → no `flush`, `stall` stays 6'b000011.
- With the macro and `STALL_TIMEOUT`=4:
  - `stallreq_if` held for 4 cycles → `stall_timeout_o`=1 after the 4th edge and stays high after the request drops.
  - A 3-cycle stall then 1 idle cycle → no trip.
- `rst` asserted mid-DRAIN → outputs return to reset values asynchronously; after release the FSM is in RUN and `busy_o`=0.
